// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled, LSB-first, 8N1-style framing with configurable stop length.
// Latency: 2 CLK synchronizer, then rx_done one CLK after the stop-bit sample tick.
// Backpressure: none; each word is presented on a single-cycle rx_done strobe and must be taken then.
module uart_receiver #(
    parameter int DATA_BITS = 8,
    parameter int STOP_TICK = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 sample_tick,
    input  logic                 rx_data,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [4:0] MID_START = 5'd7;
    localparam logic [4:0] MID_BIT   = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(STOP_TICK - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [4:0]           tick, tick_nxt;
    logic [2:0]           nbits, nbits_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 frame_err_nxt;
    logic                 rx_done_nxt;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            tick      <= '0;
            nbits     <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            frame_err <= 1'b0;
            rx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick      <= tick_nxt;
            nbits     <= nbits_nxt;
            shift_reg <= shift_nxt;
            data_out  <= data_nxt;
            frame_err <= frame_err_nxt;
            rx_done   <= rx_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tick_nxt      = tick;
        nbits_nxt     = nbits;
        shift_nxt     = shift_reg;
        data_nxt      = data_out;
        frame_err_nxt = frame_err;
        rx_done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    tick_nxt  = '0;
                end
            end

            START: begin
                if (sample_tick) begin
                    if (tick == MID_START) begin
                        tick_nxt = '0;
                        if (!rx_s) begin
                            state_nxt = DATA;
                            nbits_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick + 5'd1;
                    end
                end
            end

            DATA: begin
                if (sample_tick) begin
                    if (tick == MID_BIT) begin
                        tick_nxt  = '0;
                        shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (nbits == LAST_BIT) begin
                            state_nxt = STOP;
                        end else begin
                            nbits_nxt = nbits + 3'd1;
                        end
                    end else begin
                        tick_nxt = tick + 5'd1;
                    end
                end
            end

            STOP: begin
                if (sample_tick) begin
                    if (tick == STOP_LAST) begin
                        // A low stop bit still delivers the word, flagged.
                        tick_nxt      = '0;
                        data_nxt      = shift_reg;
                        frame_err_nxt = ~rx_s;
                        rx_done_nxt   = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        tick_nxt = tick + 5'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                tick_nxt  = '0;
                nbits_nxt = '0;
            end
        endcase
    end

endmodule
